// File: rtl/inverter_pipe.sv
// Pipelined configurable inverter for a valid/ready data stream.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cfg_load/mode/mask    - configuration strobe, mode (00 pass, 01 all,
//                           10 masked, 11 alternate) and per-bit mask
//   cnt_clr               - synchronous clear of inv_count
//   in_data/valid/ready   - upstream stream (in_ready is combinational)
//   out_data/valid/ready  - downstream stream (registered)
//   inv_count             - saturating count of delivered inverted beats
module inverter_pipe #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_load,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_mask,
    input  logic                  cnt_clr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  inv_count
);

    localparam int unsigned LAST = PIPE_STAGES - 1;

    // Reject unsupported pipeline depths at elaboration.
    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
            $error("inverter_pipe: PIPE_STAGES must be in 1..4");
        end
    endgenerate

    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic                  toggle_q;

    logic [DATA_WIDTH-1:0] data_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] inv_q;

    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  advance;
    logic                  accept;
    logic                  inv_hs;
    logic [DATA_WIDTH-1:0] eff_mask;

    // Whole pipeline moves together; it stalls only when the output is held.
    assign advance  = ~valid_q[LAST] | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    assign out_data  = data_q[LAST];
    assign out_valid = valid_q[LAST];
    assign inv_count = cnt_q;

    assign inv_hs = valid_q[LAST] & out_ready & inv_q[LAST];

    // Mask applied to the beat being accepted, from the active configuration.
    always_comb begin
        eff_mask = '0;
        case (mode_q)
            2'b00:   eff_mask = '0;
            2'b01:   eff_mask = '1;
            2'b10:   eff_mask = mask_q;
            default: eff_mask = toggle_q ? '1 : '0;
        endcase
    end

    // Active configuration and alternate-mode toggle; a load wins over a toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 2'b00;
            mask_q   <= '0;
            toggle_q <= 1'b0;
        end else if (cfg_load) begin
            mode_q   <= cfg_mode;
            mask_q   <= cfg_mask;
            toggle_q <= 1'b0;
        end else if (accept && mode_q == 2'b11) begin
            toggle_q <= ~toggle_q;
        end
    end

    // Shift register of beats with their valid and inverted flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PIPE_STAGES); i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            inv_q   <= '0;
        end else if (advance) begin
            data_q[0]  <= in_data ^ eff_mask;
            valid_q[0] <= in_valid;
            inv_q[0]   <= |eff_mask;
            for (int i = 1; i < int'(PIPE_STAGES); i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
                inv_q[i]   <= inv_q[i-1];
            end
        end
    end

    // Saturating count of delivered inverted beats; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (inv_hs && cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_inverter_pipe.sv
// Directed self-checking bench for inverter_pipe (16-bit and 2-bit counters).
module tb_inverter_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_load;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_mask;
    logic        cnt_clr;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] inv_count;

    logic        in_ready_s;
    logic [31:0] out_data_s;
    logic        out_valid_s;
    logic [1:0]  inv_count_s;

    int total = 0;
    int bad   = 0;
    logic [31:0] outq [$];

    always #5 clk = ~clk;

    inverter_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
        .cfg_mask(cfg_mask), .cnt_clr(cnt_clr), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .inv_count(inv_count)
    );

    inverter_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(2), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
        .cfg_mask(cfg_mask), .cnt_clr(cnt_clr), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .inv_count(inv_count_s)
    );

    // Record every delivered beat in order.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) outq.push_back(out_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_cfg(input logic [1:0] m, input logic [31:0] k);
        cfg_load = 1'b1; cfg_mode = m; cfg_mask = k;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_load = 1'b0; cfg_mode = 2'b00; cfg_mask = '0;
        cnt_clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
        total++; if (inv_count !== 16'd0) begin bad++; $display("FAIL reset_inv_count got=%0d exp=0", inv_count); end
        @(posedge clk); #1; rst_n = 1'b1;
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_pass();
        outq.delete();
        in_valid = 1'b1; in_data = 32'h12345678;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pass_in_ready0 got=%b exp=1", in_ready); end
        step();
        in_data = 32'hFFFF0000;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pass_in_ready1 got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin bad++; $display("FAIL pass_first v=%b got=%h exp=12345678", out_valid, out_data); end
        step();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF0000) begin bad++; $display("FAIL pass_second v=%b got=%h exp=ffff0000", out_valid, out_data); end
        idle(4);
        total++; if (outq.size() != 2) begin bad++; $display("FAIL pass_count got=%0d exp=2", outq.size()); end
        else if (outq[0] !== 32'h12345678 || outq[1] !== 32'hFFFF0000) begin bad++; $display("FAIL pass_order got=%h,%h", outq[0], outq[1]); end
        total++; if (inv_count !== 16'd0) begin bad++; $display("FAIL pass_inv_count got=%0d exp=0", inv_count); end
    endtask

    task automatic test_invert_all();
        outq.delete();
        load_cfg(2'b01, 32'h0);
        in_valid = 1'b1; in_data = 32'h00000000;
        step();
        in_data = 32'hA5A5A5A5;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inv_latency_early got=%b exp=0", out_valid); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF) begin bad++; $display("FAIL inv_first v=%b got=%h exp=ffffffff", out_valid, out_data); end
        idle(4);
        total++; if (outq.size() != 2 || outq[1] !== 32'h5A5A5A5A) begin bad++; $display("FAIL inv_second n=%0d exp=5a5a5a5a", outq.size()); end
        total++; if (inv_count !== 16'd2) begin bad++; $display("FAIL inv_count got=%0d exp=2", inv_count); end
    endtask

    task automatic test_mask_collision();
        outq.delete();
        load_cfg(2'b00, 32'h0);
        cfg_load = 1'b1; cfg_mode = 2'b10; cfg_mask = 32'h0000FFFF;
        in_valid = 1'b1; in_data = 32'hFFFFFFFF;
        step();
        cfg_load = 1'b0;
        step();
        in_valid = 1'b0;
        idle(4);
        total++; if (outq.size() != 2) begin bad++; $display("FAIL mask_count got=%0d exp=2", outq.size()); end
        else begin
            total++; if (outq[0] !== 32'hFFFFFFFF) begin bad++; $display("FAIL mask_old_cfg got=%h exp=ffffffff", outq[0]); end
            total++; if (outq[1] !== 32'hFFFF0000) begin bad++; $display("FAIL mask_new_cfg got=%h exp=ffff0000", outq[1]); end
        end
        total++; if (inv_count !== 16'd3) begin bad++; $display("FAIL mask_inv_count got=%0d exp=3", inv_count); end
    endtask

    task automatic test_alternate();
        logic [31:0] exp [5];
        exp[0] = 32'h0F0F0F0F; exp[1] = 32'hF0F0F0F0; exp[2] = 32'h0F0F0F0F;
        exp[3] = 32'hF0F0F0F0; exp[4] = 32'h0F0F0F0F;
        outq.delete();
        load_cfg(2'b11, 32'h0);
        in_valid = 1'b1; in_data = 32'h0F0F0F0F;
        idle(5);
        in_valid = 1'b0;
        load_cfg(2'b11, 32'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        idle(4);
        total++; if (outq.size() != 6) begin bad++; $display("FAIL alt_count got=%0d exp=6", outq.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                total++; if (outq[i] !== exp[i]) begin bad++; $display("FAIL alt_beat%0d got=%h exp=%h", i, outq[i], exp[i]); end
            end
            total++; if (outq[5] !== 32'h0F0F0F0F) begin bad++; $display("FAIL alt_reload got=%h exp=0f0f0f0f", outq[5]); end
        end
        total++; if (inv_count !== 16'd5) begin bad++; $display("FAIL alt_inv_count got=%0d exp=5", inv_count); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] d [6];
        logic [31:0] held;
        logic        stalled;
        int          idx;
        for (int i = 0; i < 6; i++) d[i] = 32'h11111111 * (i + 1);
        outq.delete();
        load_cfg(2'b01, 32'h0);
        idx = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (idx < 6);
            in_data   = (idx < 6) ? d[idx] : 32'h0;
            #1;
            if (stalled) begin
                total++; if (out_data !== held || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", cyc, out_data, held); end
            end
            if (out_valid && !out_ready) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (outq.size() != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", outq.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                total++; if (outq[i] !== ~d[i]) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, outq[i], ~d[i]); end
            end
        end
        total++; if (inv_count !== 16'd11) begin bad++; $display("FAIL bp_inv_count got=%0d exp=11", inv_count); end
    endtask

    task automatic test_counter();
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        total++; if (inv_count !== 16'd0 || inv_count_s !== 2'd0) begin bad++; $display("FAIL cnt_clear got=%0d/%0d exp=0/0", inv_count, inv_count_s); end
        load_cfg(2'b01, 32'h0);
        in_valid = 1'b1; in_data = 32'h00000001;
        idle(5);
        in_valid = 1'b0;
        idle(4);
        total++; if (inv_count_s !== 2'd3) begin bad++; $display("FAIL cnt_saturate got=%0d exp=3", inv_count_s); end
        total++; if (inv_count !== 16'd5) begin bad++; $display("FAIL cnt_wide got=%0d exp=5", inv_count); end
        in_valid = 1'b1; step(); in_valid = 1'b0; step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL cnt_hs_setup got=%b exp=1", out_valid); end
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        total++; if (inv_count !== 16'd0 || inv_count_s !== 2'd0) begin bad++; $display("FAIL cnt_clr_priority got=%0d/%0d exp=0/0", inv_count, inv_count_s); end
    endtask

    task automatic test_reset_midstream();
        int stale;
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        idle(2);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_inflight got=%b exp=1", out_valid); end
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL mid_flush v=%b d=%h exp=0/0", out_valid, out_data); end
        step(); rst_n = 1'b1;
        outq.delete();
        stale = 0;
        for (int i = 0; i < 5; i++) begin step(); if (out_valid) stale++; end
        total++; if (stale != 0 || outq.size() != 0) begin bad++; $display("FAIL mid_stale got=%0d/%0d exp=0/0", stale, outq.size()); end
        in_valid = 1'b1; in_data = 32'h13579BDF; step(); in_valid = 1'b0;
        idle(3);
        total++; if (outq.size() != 1 || outq[0] !== 32'h13579BDF) begin bad++; $display("FAIL mid_mode_reset n=%0d exp=13579bdf", outq.size()); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_invert_all();
        test_mask_collision();
        test_alternate();
        test_back_pressure();
        test_counter();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inverter_pipe.md
Name: inverter_pipe

Overview:
- Pipelined, parametrised successor to the combinational bitwise inverter.
- Applies a configurable inversion (none, all bits, masked bits, or alternating beats) to a valid/ready data stream.
- Programmable latency of PIPE_STAGES cycles and full back-pressure support.
- Sits between streaming datapath blocks and keeps a saturating count of inverted beats for debug and status.

Parameters:
- DATA_WIDTH, 32: data and mask width in bits; legal values 1 or more.
- PIPE_STAGES, 2: register stages from input to output; legal range 1..4.
- CNT_WIDTH, 16: width of the inverted-beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cfg_load  input  1  single-cycle strobe; captures cfg_mode and cfg_mask.
- cfg_mode  input  2  00 pass, 01 invert all, 10 invert masked bits, 11 alternate (invert all on every second beat).
- cfg_mask  input  DATA_WIDTH  per-bit invert enable, used in mode 10.
- cnt_clr  input  1  synchronous clear of inv_count.
- in_data  input  DATA_WIDTH  input beat.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- out_data  output  DATA_WIDTH  processed beat.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- inv_count  output  CNT_WIDTH  count of delivered beats that had at least one bit inverted; saturates.

Behaviour:
- Reset (async assert, sync-safe release):
  - all stage valids = 0; out_valid = 0; out_data = 0.
  - active mode = 00; active mask = 0; alternate toggle = 0; inv_count = 0.
  - in_ready = 1 in the first cycle after reset release.
- Config:
  - On a cycle with cfg_load = 1, the active mode and mask registers update at that edge.
  - The toggle clears to 0 at the same edge.
  - A beat accepted in the same cycle as cfg_load uses the OLD configuration.
  - Beats already in the pipeline are never re-processed.
- Transform at acceptance (in_valid and in_ready):
  - Effective mask: mode 00 -> all zeros; 01 -> all ones; 10 -> active mask; 11 -> all ones if toggle = 1, else all zeros.
  - Data entering stage 1 = in_data XOR effective mask.
  - A flag "inverted" = (effective mask != 0) travels with the beat.
  - In mode 11, the toggle inverts on every accepted beat; it holds when no beat is accepted and in other modes.
- Pipeline and handshake:
  - Global stall: advance = ~out_valid | out_ready.
  - in_ready = advance, purely combinational from out_valid and out_ready. It does not depend on in_valid.
  - When advance = 1, every stage shifts one position and stage 1 loads the new beat with valid = in_valid.
  - When advance = 0, all stages hold.
  - Bubbles are not collapsed.
  - Latency: beat accepted at edge N appears with out_valid = 1 after edge N + PIPE_STAGES - 1, provided no stall occurs. PIPE_STAGES = 1 -> out_valid in the cycle after acceptance.
  - out_data and out_valid are stable while out_valid = 1 and out_ready = 0.
  - Throughput: 1 beat/cycle while out_ready = 1.
- Counter:
  - inv_count increments on each output handshake (out_valid and out_ready) whose inverted flag = 1.
  - Saturates at all ones and does not wrap.
  - cnt_clr has priority over an increment in the same cycle; result is 0.
- Reset mid-stream: all in-flight beats are discarded, and no output handshake occurs until new beats are accepted.
- Illegal PIPE_STAGES (outside 1..4): elaboration error.

Test Plan:
- Reset and pass:
  - Stimulus: after reset, mode 00; send 0x12345678, 0xFFFF0000.
  - Required: same values out after 2 cycles, back-to-back; in_ready = 1 throughout; inv_count = 0.
- Invert all and latency:
  - Stimulus: cfg_load mode 01; send 0x00000000, 0xA5A5A5A5.
  - Required: 0xFFFFFFFF, then 0x5A5A5A5A, first out_valid at cycle 2 after acceptance; inv_count = 2.
- Masked mode with config collision:
  - Stimulus: beat 0xFFFFFFFF accepted in the same cycle as cfg_load mode 10, mask 0x0000FFFF; then send 0xFFFFFFFF again.
  - Required: first output 0xFFFFFFFF (old mode 00); second 0xFFFF0000.
- Alternate mode:
  - Stimulus: mode 11; send four beats of 0x0F0F0F0F.
  - Required: 0x0F0F0F0F, 0xF0F0F0F0, 0x0F0F0F0F, 0xF0F0F0F0; inv_count += 2.
  - Then cfg_load mode 11 again; next beat passes unchanged.
- Back-pressure:
  - Stimulus: mode 01; stream 6 beats with out_ready low for 3 cycles mid-stream.
  - Required: in_ready = 0 while out_valid = 1 and out_ready = 0; out_data held stable; no loss or duplication; order preserved.
- Counter saturation, clear, and reset:
  - Stimulus: CNT_WIDTH = 2, mode 01, 5 beats.
  - Required: inv_count = 3 (saturated).
  - cnt_clr coincident with a handshake -> 0.
  - Assert rst_n low with 2 beats in flight -> out_valid = 0 immediately; no stale output after release.
